// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared types and constants for the BrainDrizzle router slice.
//            Holds the allocator state encoding and the flit/link widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Allocator ownership of one output port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } alloc_state_t;

    // Flit payload width.
    localparam int FLIT_W = 11;

    // Physical link width (flit payload plus link-level sideband).
    localparam int LINK_W = 14;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_allocator.sv
`default_nettype none
// ============================================================================
// Module   : router_allocator
// Purpose  : Wormhole output allocator for one router output port. Two input
//            controllers compete for the port. Arbitration is round-robin per
//            packet. A grant is held from the head flit until the tail flit
//            has transferred. Accepted flits are registered one cycle and
//            written into the downstream output FIFO.
// Ports    : clk           - system clock
//            rst_n         - asynchronous active-low reset
//            req_0/1       - requester has a valid flit on data_in_0/1
//            tail_0/1      - current flit is the last flit of its packet
//            data_in_0/1   - requester flit
//            out_FIFO_full - output FIFO cannot accept a write
//            ready_0/1     - flit accepted this cycle when req is high
//            out_FIFO_wr   - output FIFO write strobe
//            data_out      - flit to the output FIFO
//            busy          - a packet currently holds the port
//            pkt_count     - number of tail flits forwarded (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module router_allocator
    import router_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              tail_0,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              req_1,
    input  logic              tail_1,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              out_FIFO_full,
    output logic              ready_0,
    output logic              ready_1,
    output logic              out_FIFO_wr,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_count
);

    alloc_state_t      r_state;
    alloc_state_t      w_state_nxt;
    logic              r_ptr;       // requester that wins the next tie in IDLE
    logic              r_wr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_xfer_0;
    logic              w_xfer_1;
    logic              w_tail_xfer_0;
    logic              w_tail_xfer_1;

    // Ready depends only on ownership and FIFO headroom, never on req, so a
    // requester can safely hold its flit until it observes ready.
    assign ready_0       = (r_state == GRANT0) & ~out_FIFO_full;
    assign ready_1       = (r_state == GRANT1) & ~out_FIFO_full;

    assign w_xfer_0      = req_0 & ready_0;
    assign w_xfer_1      = req_1 & ready_1;
    assign w_tail_xfer_0 = w_xfer_0 & tail_0;
    assign w_tail_xfer_1 = w_xfer_1 & tail_1;

    // ------------------------------------------------------------------------
    // Next-state logic. On a tail transfer the other requester is served
    // first if it is waiting, so back-to-back packets alternate with no
    // bubble. A granted requester that drops req mid-packet keeps the port.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_0 && req_1) begin
                    w_state_nxt = r_ptr ? GRANT1 : GRANT0;
                end else if (req_0) begin
                    w_state_nxt = GRANT0;
                end else if (req_1) begin
                    w_state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (w_tail_xfer_0) begin
                    if (req_1) begin
                        w_state_nxt = GRANT1;
                    end else if (req_0) begin
                        w_state_nxt = GRANT0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GRANT1: begin
                if (w_tail_xfer_1) begin
                    if (req_0) begin
                        w_state_nxt = GRANT0;
                    end else if (req_1) begin
                        w_state_nxt = GRANT1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority moves only when a packet completes, giving per-packet fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_tail_xfer_0) begin
            r_ptr <= 1'b1;
        end else if (w_tail_xfer_1) begin
            r_ptr <= 1'b0;
        end
    end

    // Output register: data_out keeps its last value when no write occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= 1'b0;
            r_data <= '0;
        end else begin
            r_wr <= w_xfer_0 | w_xfer_1;
            if (w_xfer_0) begin
                r_data <= data_in_0;
            end else if (w_xfer_1) begin
                r_data <= data_in_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tail_xfer_0 || w_tail_xfer_1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_FIFO_wr = r_wr;
    assign data_out    = r_data;
    assign busy        = (r_state != IDLE);
    assign pkt_count   = r_cnt;

endmodule : router_allocator
`default_nettype wire

// File: tb/tb_router_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_allocator
// Purpose  : Self-checking bench for router_allocator. A port-ownership model
//            predicts every output each cycle; directed scenarios add literal
//            expectations on the forwarded flit stream and packet counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_allocator;

    localparam int DW = 11;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          req_0, tail_0, req_1, tail_1;
    logic [DW-1:0] data_in_0, data_in_1;
    logic          out_FIFO_full;
    logic          ready_0, ready_1, out_FIFO_wr, busy;
    logic [DW-1:0] data_out;
    logic [CW-1:0] pkt_count;

    router_allocator #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_0         (req_0),
        .tail_0        (tail_0),
        .data_in_0     (data_in_0),
        .req_1         (req_1),
        .tail_1        (tail_1),
        .data_in_1     (data_in_1),
        .out_FIFO_full (out_FIFO_full),
        .ready_0       (ready_0),
        .ready_1       (ready_1),
        .out_FIFO_wr   (out_FIFO_wr),
        .data_out      (data_out),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester flit queues: {tail, data} -------------------
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];

    // Present the head flit just after the falling edge; retire it if the
    // allocator showed ready just before the rising edge.
    always begin
        @(negedge clk); #1;
        if (q0.size() > 0) begin
            req_0 = 1'b1; tail_0 = q0[0][DW]; data_in_0 = q0[0][DW-1:0];
        end else begin
            req_0 = 1'b0;
        end
        #3;
        if (req_0 && ready_0 && rst_n) void'(q0.pop_front());
    end

    always begin
        @(negedge clk); #1;
        if (q1.size() > 0) begin
            req_1 = 1'b1; tail_1 = q1[0][DW]; data_in_1 = q1[0][DW-1:0];
        end else begin
            req_1 = 1'b0;
        end
        #3;
        if (req_1 && ready_1 && rst_n) void'(q1.pop_front());
    end

    // ---------------- behavioural model: who owns the port -----------------
    int            m_owner;   // -1 free, else requester index
    int            m_turn;    // requester favoured on a simultaneous request
    logic          m_wr;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_turn = 0; m_wr = 1'b0; m_data = '0; m_cnt = '0;
        end else begin
            bit x0, x1, rq_me, rq_other;
            int me;
            x0 = req_0 && (m_owner == 0) && !out_FIFO_full;
            x1 = req_1 && (m_owner == 1) && !out_FIFO_full;
            m_wr = x0 || x1;
            if (x0) m_data = data_in_0;
            else if (x1) m_data = data_in_1;
            if (m_owner == -1) begin
                if (req_0 && req_1) m_owner = m_turn;
                else if (req_0)     m_owner = 0;
                else if (req_1)     m_owner = 1;
            end else if ((x0 && tail_0) || (x1 && tail_1)) begin
                me       = m_owner;
                rq_me    = (me == 0) ? req_0 : req_1;
                rq_other = (me == 0) ? req_1 : req_0;
                m_turn   = 1 - me;
                m_cnt    = m_cnt + 1'b1;
                if (rq_other)   m_owner = 1 - me;
                else if (rq_me) m_owner = me;
                else            m_owner = -1;
            end
        end
    end

    // ---------------- per-cycle compare against the model -----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_0",   ready_0,     (m_owner == 0) && !out_FIFO_full);
            chk("ready_1",   ready_1,     (m_owner == 1) && !out_FIFO_full);
            chk("wr",        out_FIFO_wr, m_wr);
            chk("data_out",  data_out,    m_data);
            chk("busy",      busy,        m_owner != -1);
            chk("pkt_count", pkt_count,   m_cnt);
        end
    end

    // ---------------- write log with cycle stamps ---------------------------
    logic [DW-1:0] wlog[$];
    int            wcyc[$];
    int            cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n && out_FIFO_wr) begin
            wlog.push_back(data_out);
            wcyc.push_back(cyc);
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic tick();
        @(negedge clk); #2;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (wlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, wlog.size() >= n, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        q0.delete(); q1.delete();
        out_FIFO_full = 1'b0;
        tick();
        rst_n = 1'b1;
        wlog.delete(); wcyc.delete();
    endtask

    logic [DW-1:0] exp_q[$];

    // Compare the logged write stream with exp_q; entries from index
    // consec_from onward must be written on consecutive cycles.
    task automatic chk_seq(input string name, input int consec_from);
        chk({name, "_len"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_flit%0d", name, i),
                (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEAD, exp_q[i]);
            if (i >= consec_from && i > 0 && i < wlog.size())
                chk($sformatf("%s_gap%0d", name, i), wcyc[i] - wcyc[i-1], 1);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ready_0"},   ready_0,     0);
        chk({name, "_ready_1"},   ready_1,     0);
        chk({name, "_wr"},        out_FIFO_wr, 0);
        chk({name, "_data_out"},  data_out,    0);
        chk({name, "_busy"},      busy,        0);
        chk({name, "_pkt_count"}, pkt_count,   0);
    endtask

    // ---------------- directed scenarios -----------------------------------
    initial begin
        int lowcnt;
        int viol;
        rst_n = 1'b0;
        req_0 = 1'b0; tail_0 = 1'b0; data_in_0 = '0;
        req_1 = 1'b0; tail_1 = 1'b0; data_in_1 = '0;
        out_FIFO_full = 1'b0;
        #1;
        chk_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;

        // Contention: both rise together, pointer 0 -> requester 0 first.
        do_reset();
        q0.push_back({1'b0, 11'h101});
        q0.push_back({1'b0, 11'h102});
        q0.push_back({1'b1, 11'h103});
        q1.push_back({1'b1, 11'h201});
        wait_writes(4, 50, "cont_timeout");
        tick(); tick();
        exp_q = {11'h101, 11'h102, 11'h103, 11'h201};
        chk_seq("cont", 1);
        chk("cont_pkt_count", pkt_count, 2);

        // Fairness: continuous single-flit packets alternate 0,1,0,1,...
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            q0.push_back({1'b1, 11'h110 + 11'(i)});
            q1.push_back({1'b1, 11'h210 + 11'(i)});
        end
        wait_writes(6, 50, "fair_timeout");
        tick(); tick();
        exp_q = {11'h111, 11'h211, 11'h112, 11'h212, 11'h113, 11'h213};
        chk_seq("fair", 1);
        chk("fair_pkt_count", pkt_count, 6);

        // Backpressure: full for 4 cycles after the first flit is written.
        do_reset();
        q0.push_back({1'b0, 11'h301});
        q0.push_back({1'b0, 11'h302});
        q0.push_back({1'b1, 11'h303});
        wait_writes(1, 20, "bp_timeout1");
        out_FIFO_full = 1'b1;
        lowcnt = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (!ready_0) lowcnt++;
            tick();
        end
        out_FIFO_full = 1'b0;
        #1;
        chk("bp_low_cycles", lowcnt, 4);
        chk("bp_ready_after", ready_0, 1);
        chk("bp_held_writes", wlog.size(), 1);
        wait_writes(3, 20, "bp_timeout3");
        tick(); tick(); tick();
        exp_q = {11'h301, 11'h302, 11'h303};
        chk_seq("bp", 2);

        // Wormhole lock: requester 0 pauses mid-packet, requester 1 waits.
        do_reset();
        q0.push_back({1'b0, 11'h401});
        q1.push_back({1'b1, 11'h501});
        wait_writes(1, 20, "wh_timeout1");
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            if (ready_1) viol++;
            tick();
        end
        chk("wh_busy_locked", busy, 1);
        q0.push_back({1'b1, 11'h402});
        while (wlog.size() < 2 && viol < 100) begin
            if (ready_1) viol++;
            tick();
            if (wlog.size() < 2) viol = viol + 0;
        end
        chk("wh_ready_1_locked", viol, 0);
        wait_writes(3, 20, "wh_timeout3");
        tick();
        exp_q = {11'h401, 11'h402, 11'h501};
        chk_seq("wh", 2);
        chk("wh_pkt_count", pkt_count, 2);

        // Reset mid-packet, then a fresh grant one cycle after request.
        do_reset();
        q0.push_back({1'b0, 11'h601});
        q0.push_back({1'b0, 11'h602});
        q0.push_back({1'b1, 11'h603});
        wait_writes(1, 20, "rst_timeout");
        chk("rst_pre_ready_0", ready_0, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        q0.delete();
        tick();
        rst_n = 1'b1;
        wlog.delete(); wcyc.delete();
        q0.push_back({1'b1, 11'h611});
        tick();
        chk("rst_post_ready_early", ready_0, 0);
        tick();
        chk("rst_post_ready_0", ready_0, 1);
        wait_writes(1, 20, "rst_timeout2");
        tick(); tick();
        exp_q = {11'h611};
        chk_seq("rst", 1);
        chk("rst_pkt_count", pkt_count, 1);

        // Counter wrap: 65535 packets, then one more.
        do_reset();
        for (int i = 0; i < 65535; i++) q0.push_back({1'b1, 11'(i)});
        wait_writes(65535, 70000, "wrap_timeout1");
        chk("wrap_ffff", pkt_count, 16'hFFFF);
        q0.push_back({1'b1, 11'h7AA});
        wait_writes(65536, 20, "wrap_timeout2");
        chk("wrap_zero", pkt_count, 16'h0000);
        chk("wrap_last_flit", data_out, 11'h7AA);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_router_allocator
`default_nettype wire

// File: doc/router_allocator.md
Name: router_allocator

Overview:
- Wormhole output allocator for one BrainDrizzle router output port (top, bottom or BD).
- Two input controllers request the port. Arbitration is round-robin per packet.
- The grant is held from the head flit until the tail flit has transferred.
- Granted flits are registered and written into the output FIFO; one instance sits in front of each output FIFO.

Parameters:
- DATA_W, 11, flit payload width.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_0  in  1  requester 0 has a valid flit on data_in_0.
- tail_0  in  1  current flit of requester 0 is its packet's last flit.
- data_in_0  in  DATA_W  requester 0 flit.
- req_1  in  1  requester 1 has a valid flit on data_in_1.
- tail_1  in  1  current flit of requester 1 is its packet's last flit.
- data_in_1  in  DATA_W  requester 1 flit.
- out_FIFO_full  in  1  output FIFO cannot accept a write.
- ready_0  out  1  requester 0 flit accepted this cycle when req_0 is high.
- ready_1  out  1  requester 1 flit accepted this cycle when req_1 is high.
- out_FIFO_wr  out  1  output FIFO write strobe.
- data_out  out  DATA_W  flit to the output FIFO.
- busy  out  1  a packet currently holds the port.
- pkt_count  out  CNT_W  number of tail flits forwarded.

Behaviour:
- Reset values (asynchronous on rst_n low, also mid-packet): state IDLE, priority pointer = 0, ready_0 = ready_1 = 0, out_FIFO_wr = 0, data_out = 0, busy = 0, pkt_count = 0. A packet interrupted by reset is abandoned; no partial-packet recovery.
- States: IDLE, GRANT0, GRANT1; state is registered.
- IDLE transitions:
  - only req_0 -> GRANT0.
  - only req_1 -> GRANT1.
  - both -> GRANT to the requester named by the pointer.
  - none -> stay in IDLE.
  - No flit is accepted in IDLE, so the first flit is accepted 1 cycle after req.
- Ready is combinational from state: ready_i = (state == GRANTi) & ~out_FIFO_full. The ready of the ungranted requester is always 0.
- Transfer: xfer_i = req_i & ready_i. The requester holds data and tail stable until it sees ready_i.
- Output latency is 1 cycle and the output is registered:
  - cycle after xfer_i: out_FIFO_wr = 1, data_out = data_in_i captured at the transfer.
  - otherwise out_FIFO_wr = 0 and data_out holds its last value.
- FIFO headroom: because of this latency, out_FIFO_full must assert when at most 1 entry is free. This is a system requirement on the connected FIFO.
- Tail transfer (xfer_i & tail_i) while in GRANTi:
  - pointer <= other requester.
  - pkt_count <= pkt_count + 1, wrapping modulo 2^CNT_W.
  - if req of the other requester is high that cycle -> GRANTother, with no bubble.
  - else if req_i is high -> GRANTi, so the same requester sends its next packet.
  - else -> IDLE.
- A single-flit packet (head = tail) follows the same tail rule.
- req_i dropping mid-packet: the grant is held in GRANTi indefinitely (wormhole lock). The other requester stalls.
- out_FIFO_full high: ready is 0 and the state holds. No flit is lost or duplicated.
- busy = (state != IDLE).

Decomposition:
- Package router_pkg holds:
  - typedef enum alloc_state_t {IDLE, GRANT0, GRANT1};
  - localparam FLIT_W = 11;
  - localparam LINK_W = 14.
- No sub-module. FSM, pointer, output register and counter all live in router_allocator.

Test Plan:
- Reset mid-packet: rst_n low during a GRANT0 transfer -> all outputs 0 in the same cycle; after release, req_0 raised -> ready_0 = 1 on the next cycle.
- Contention: req_0 and req_1 rise together in IDLE with pointer 0.
  - Requester 0 sends a 3-flit packet 0x101, 0x102, 0x103(tail).
  - Required: data_out shows 0x101..0x103 on consecutive out_FIFO_wr cycles.
  - Then requester 1 (0x201 tail) is granted with no idle cycle; pkt_count = 2.
- Fairness: both requesters continuously send 1-flit packets -> grants alternate 0,1,0,1; pkt_count increments each cycle after the first.
- Backpressure: out_FIFO_full high for 4 cycles mid-packet -> ready_0 = 0 for exactly those cycles; the flit sequence is intact with no duplicate writes.
- Wormhole lock: requester 0 sends a head flit, drops req_0 for 5 cycles, then sends the tail flit; req_1 is held high throughout.
  - Required: ready_1 = 0 until the tail transfers; requester 1 is granted on the next cycle.
- Counter wrap: preload by sending 65535 packets, then 1 more -> pkt_count goes 0xFFFF -> 0x0000.
